// File: rtl/voice_scheduler.sv
`default_nettype none
// ============================================================================
// voice_scheduler : sweeps all voices per tick48k, issuing R/L wavetable strobes.
// Optional: VOICE_PHASE_RESET_EN clears a voice's phase on phase_inc write. Rev 1.0
// ============================================================================
module voice_scheduler #(
  parameter int NVOICES = 16,
  parameter int SLOT    = 8,
  parameter int PHASE_W = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick48k,
  input  logic        voice_we,
  input  logic [5:0]  voice_sel,
  input  logic [1:0]  voice_field,
  input  logic [23:0] voice_wdata,
  output logic [9:0]  wavetable_r,
  output logic        wavetable_r_valid,
  output logic [9:0]  wavetable_l,
  output logic        wavetable_l_valid,
  output logic [17:0] volume_adsr,
  output logic [17:0] velocity,
  output logic        busy,
  output logic        sweep_done,
  output logic        overrun
);

  localparam int VW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
  localparam int SW = $clog2(SLOT);

  typedef enum logic [0:0] {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [VW-1:0]       voice_q, voice_d;
  logic [SW-1:0]       slot_q, slot_d;

  logic [PHASE_W-1:0]  phase_inc_q [NVOICES];
  logic [PHASE_W-1:0]  phase_inc_d [NVOICES];
  logic [PHASE_W-1:0]  phase_q     [NVOICES];
  logic [PHASE_W-1:0]  phase_d     [NVOICES];
  logic [9:0]          l_offset_q  [NVOICES];
  logic [9:0]          l_offset_d  [NVOICES];
  logic [17:0]         vel_mem_q   [NVOICES];
  logic [17:0]         vel_mem_d   [NVOICES];
  logic [17:0]         env_mem_q   [NVOICES];
  logic [17:0]         env_mem_d   [NVOICES];

  logic [PHASE_W-1:0]  cur_inc_q, cur_inc_d;
  logic [9:0]          cur_loff_q, cur_loff_d;
  logic                cur_active_q, cur_active_d;

  logic [9:0]          wav_r_q, wav_r_d, wav_l_q, wav_l_d;
  logic                wav_r_valid_q, wav_r_valid_d, wav_l_valid_q, wav_l_valid_d;
  logic [17:0]         vol_q, vol_d, vel_q, vel_d;
  logic                done_q, done_d, overrun_q, overrun_d;

  always_comb begin
    state_d       = state_q;
    voice_d       = voice_q;
    slot_d        = slot_q;
    phase_inc_d   = phase_inc_q;
    phase_d       = phase_q;
    l_offset_d    = l_offset_q;
    vel_mem_d     = vel_mem_q;
    env_mem_d     = env_mem_q;
    cur_inc_d     = cur_inc_q;
    cur_loff_d    = cur_loff_q;
    cur_active_d  = cur_active_q;
    wav_r_d       = wav_r_q;
    wav_r_valid_d = 1'b0;
    wav_l_d       = wav_l_q;
    wav_l_valid_d = 1'b0;
    vol_d         = vol_q;
    vel_d         = vel_q;
    done_d        = 1'b0;
    overrun_d     = overrun_q;

    case (state_q)
      IDLE: begin
        if (tick48k) begin
          state_d = SWEEP;
          voice_d = '0;
          slot_d  = '0;
        end
      end
      SWEEP: begin
        if (tick48k) overrun_d = 1'b1;
        // Slot cycle 0 reads the register file before any same-cycle write lands.
        if (slot_q == '0) begin
          cur_inc_d    = phase_inc_q[voice_q];
          cur_loff_d   = l_offset_q[voice_q];
          cur_active_d = (phase_inc_q[voice_q] != '0);
          vol_d        = env_mem_q[voice_q];
          vel_d        = vel_mem_q[voice_q];
          if (phase_inc_q[voice_q] != '0) begin
            wav_r_d       = phase_q[voice_q][PHASE_W-1 -: 10];
            wav_r_valid_d = 1'b1;
          end
        end
        if (slot_q == SW'(1) && cur_active_q) begin
          wav_l_d       = wav_r_q + cur_loff_q;
          wav_l_valid_d = 1'b1;
          for (int v = 0; v < NVOICES; v++) begin
            if (voice_q == VW'(v)) phase_d[v] = phase_q[v] + cur_inc_q;
          end
        end
        if (slot_q == SW'(SLOT - 1)) begin
          slot_d = '0;
          if (voice_q == VW'(NVOICES - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            voice_d = voice_q + VW'(1);
          end
        end else begin
          slot_d = slot_q + SW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Writes come last so a phase clear overrides a same-cycle increment.
    for (int v = 0; v < NVOICES; v++) begin
      if (voice_we && voice_sel == 6'(v)) begin
        case (voice_field)
          2'd0: begin
            phase_inc_d[v] = PHASE_W'(voice_wdata);
`ifdef VOICE_PHASE_RESET_EN
            phase_d[v] = '0;
`endif
          end
          2'd1: l_offset_d[v] = voice_wdata[9:0];
          2'd2: vel_mem_d[v]  = voice_wdata[17:0];
          2'd3: env_mem_d[v]  = voice_wdata[17:0];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      voice_q       <= '0;
      slot_q        <= '0;
      for (int v = 0; v < NVOICES; v++) begin
        phase_inc_q[v] <= '0;
        phase_q[v]     <= '0;
        l_offset_q[v]  <= '0;
        vel_mem_q[v]   <= '0;
        env_mem_q[v]   <= '0;
      end
      cur_inc_q     <= '0;
      cur_loff_q    <= '0;
      cur_active_q  <= 1'b0;
      wav_r_q       <= '0;
      wav_r_valid_q <= 1'b0;
      wav_l_q       <= '0;
      wav_l_valid_q <= 1'b0;
      vol_q         <= '0;
      vel_q         <= '0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      voice_q       <= voice_d;
      slot_q        <= slot_d;
      phase_inc_q   <= phase_inc_d;
      phase_q       <= phase_d;
      l_offset_q    <= l_offset_d;
      vel_mem_q     <= vel_mem_d;
      env_mem_q     <= env_mem_d;
      cur_inc_q     <= cur_inc_d;
      cur_loff_q    <= cur_loff_d;
      cur_active_q  <= cur_active_d;
      wav_r_q       <= wav_r_d;
      wav_r_valid_q <= wav_r_valid_d;
      wav_l_q       <= wav_l_d;
      wav_l_valid_q <= wav_l_valid_d;
      vol_q         <= vol_d;
      vel_q         <= vel_d;
      done_q        <= done_d;
      overrun_q     <= overrun_d;
    end
  end

  assign wavetable_r       = wav_r_q;
  assign wavetable_r_valid = wav_r_valid_q;
  assign wavetable_l       = wav_l_q;
  assign wavetable_l_valid = wav_l_valid_q;
  assign volume_adsr       = vol_q;
  assign velocity          = vel_q;
  assign busy              = (state_q == SWEEP);
  assign sweep_done        = done_q;
  assign overrun           = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_voice_scheduler.sv
`default_nettype none
// ============================================================================
// tb_voice_scheduler : randomized self-checking bench with a tick-relative model.
// Rev 1.0
// ============================================================================
module tb_voice_scheduler;
  localparam int NV        = 16;
  localparam int SL        = 8;
  localparam int PW        = 24;
  localparam int SWEEP_LEN = NV * SL;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick48k = 1'b0;
  logic        voice_we = 1'b0;
  logic [5:0]  voice_sel = '0;
  logic [1:0]  voice_field = '0;
  logic [23:0] voice_wdata = '0;
  logic [9:0]  wavetable_r, wavetable_l;
  logic        wavetable_r_valid, wavetable_l_valid;
  logic [17:0] volume_adsr, velocity;
  logic        busy, sweep_done, overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  voice_scheduler #(.NVOICES(NV), .SLOT(SL), .PHASE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .tick48k(tick48k),
    .voice_we(voice_we), .voice_sel(voice_sel), .voice_field(voice_field),
    .voice_wdata(voice_wdata),
    .wavetable_r(wavetable_r), .wavetable_r_valid(wavetable_r_valid),
    .wavetable_l(wavetable_l), .wavetable_l_valid(wavetable_l_valid),
    .volume_adsr(volume_adsr), .velocity(velocity),
    .busy(busy), .sweep_done(sweep_done), .overrun(overrun)
  );

  // Reference register file and expected output state
  int unsigned m_inc[NV], m_loff[NV], m_vel[NV], m_env[NV], m_phase[NV];
  int unsigned s_r[NV], s_loff[NV], s_vel[NV], s_env[NV], s_inc[NV];
  bit          s_act[NV];
  int unsigned e_r, e_l, e_vol, e_vel;
  bit          e_ovr;
  int          log_r[NV], log_l[NV], log_rn[NV], log_ln[NV], log_vel[NV];
  int          done_n, busy_cnt;

  function automatic void model_reset();
    for (int v = 0; v < NV; v++) begin
      m_inc[v] = 0; m_loff[v] = 0; m_vel[v] = 0; m_env[v] = 0; m_phase[v] = 0;
    end
    e_r = 0; e_l = 0; e_vol = 0; e_vel = 0; e_ovr = 1'b0;
  endfunction

  function automatic void model_write(int sel, int field, int unsigned data);
    if (sel >= NV) return;
    case (field)
      0: begin
        m_inc[sel] = data & 32'hFFFFFF;
`ifdef VOICE_PHASE_RESET_EN
        m_phase[sel] = 0;
`endif
      end
      1: m_loff[sel] = data & 32'h3FF;
      2: m_vel[sel]  = data & 32'h3FFFF;
      default: m_env[sel] = data & 32'h3FFFF;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic write_voice(input int sel, input int field, input int unsigned data);
    @(negedge clk);
    voice_we = 1'b1; voice_sel = 6'(sel); voice_field = 2'(field); voice_wdata = 24'(data);
    model_write(sel, field, data);
    @(negedge clk);
    voice_we = 1'b0;
  endtask

  // Ticks once and checks every output on every cycle of the sweep and shortly after.
  task automatic run_sweep(input int tick_at, input int wr_at, input int wr_sel,
                           input int wr_field, input int unsigned wr_data);
    bit in_sw, exp_rv, exp_lv, exp_busy, exp_done, ovr_pend;
    int k, p;
    for (int v = 0; v < NV; v++) begin
      log_r[v] = -1; log_l[v] = -1; log_rn[v] = -1; log_ln[v] = -1; log_vel[v] = -1;
    end
    done_n = -1; busy_cnt = 0;
    @(negedge clk);
    tick48k = 1'b1;
    @(posedge clk); #1;
    tick48k = 1'b0;
    for (int n = 1; n <= SWEEP_LEN + 3; n++) begin
      ovr_pend = 1'b0;
      if (n <= SWEEP_LEN && (n - 1) % SL == 0) begin
        k = (n - 1) / SL;
        s_act[k] = (m_inc[k] != 0); s_inc[k] = m_inc[k]; s_loff[k] = m_loff[k];
        s_vel[k] = m_vel[k]; s_env[k] = m_env[k]; s_r[k] = m_phase[k] >> (PW - 10);
      end
      in_sw = (n >= 2 && n <= SWEEP_LEN + 1);
      k = in_sw ? (n - 2) / SL : 0;
      p = in_sw ? (n - 2) % SL : -1;
      exp_rv = in_sw && p == 0 && s_act[k];
      exp_lv = in_sw && p == 1 && s_act[k];
      if (in_sw && p == 0) begin
        e_vol = s_env[k]; e_vel = s_vel[k];
        if (s_act[k]) begin
          e_r = s_r[k];
          m_phase[k] = (m_phase[k] + s_inc[k]) & 32'hFFFFFF;
        end
      end
      if (exp_lv) e_l = (s_r[k] + s_loff[k]) & 32'h3FF;
      exp_busy = (n <= SWEEP_LEN);
      exp_done = (n == SWEEP_LEN + 1);

      checks += 9;
      if (wavetable_r_valid !== exp_rv) begin errors++; $display("FAIL r_valid n=%0d got %0b exp %0b", n, wavetable_r_valid, exp_rv); end
      if (wavetable_l_valid !== exp_lv) begin errors++; $display("FAIL l_valid n=%0d got %0b exp %0b", n, wavetable_l_valid, exp_lv); end
      if (wavetable_r !== 10'(e_r)) begin errors++; $display("FAIL r_addr n=%0d got %0d exp %0d", n, wavetable_r, e_r); end
      if (wavetable_l !== 10'(e_l)) begin errors++; $display("FAIL l_addr n=%0d got %0d exp %0d", n, wavetable_l, e_l); end
      if (volume_adsr !== 18'(e_vol)) begin errors++; $display("FAIL volume n=%0d got %0h exp %0h", n, volume_adsr, e_vol); end
      if (velocity !== 18'(e_vel)) begin errors++; $display("FAIL velocity n=%0d got %0h exp %0h", n, velocity, e_vel); end
      if (busy !== exp_busy) begin errors++; $display("FAIL busy n=%0d got %0b exp %0b", n, busy, exp_busy); end
      if (sweep_done !== exp_done) begin errors++; $display("FAIL sweep_done n=%0d got %0b exp %0b", n, sweep_done, exp_done); end
      if (overrun !== e_ovr) begin errors++; $display("FAIL overrun n=%0d got %0b exp %0b", n, overrun, e_ovr); end

      if (wavetable_r_valid && in_sw) begin log_r[k] = int'(wavetable_r); log_rn[k] = n; end
      if (wavetable_l_valid && in_sw) begin log_l[k] = int'(wavetable_l); log_ln[k] = n; end
      if (in_sw && p == 0) log_vel[k] = int'(velocity);
      if (busy) busy_cnt++;
      if (sweep_done) done_n = n;

      if (n == tick_at) begin
        tick48k = 1'b1;
        if (n <= SWEEP_LEN) ovr_pend = 1'b1;
      end
      if (n == wr_at) begin
        voice_we = 1'b1; voice_sel = 6'(wr_sel); voice_field = 2'(wr_field); voice_wdata = 24'(wr_data);
        model_write(wr_sel, wr_field, wr_data);
      end
      @(posedge clk); #1;
      tick48k = 1'b0; voice_we = 1'b0;
      if (ovr_pend) e_ovr = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (wavetable_r !== 10'd0 || wavetable_l !== 10'd0) begin errors++; $display("FAIL reset_addr got r=%0d l=%0d exp 0", wavetable_r, wavetable_l); end
    if (wavetable_r_valid !== 1'b0 || wavetable_l_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b%0b exp 00", wavetable_r_valid, wavetable_l_valid); end
    if (volume_adsr !== 18'd0 || velocity !== 18'd0) begin errors++; $display("FAIL reset_env got %0h/%0h exp 0", volume_adsr, velocity); end
    if (busy !== 1'b0 || sweep_done !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL reset_status got %0b%0b%0b exp 000", busy, sweep_done, overrun); end
    run_sweep(-1, -1, 0, 0, 0);
    checks += 3;
    if (done_n !== 129) begin errors++; $display("FAIL idle_done_time got %0d exp 129", done_n); end
    if (busy_cnt !== 128) begin errors++; $display("FAIL idle_busy_len got %0d exp 128", busy_cnt); end
    if (log_rn[0] !== -1 || log_rn[15] !== -1) begin errors++; $display("FAIL idle_no_strobe got %0d exp -1", log_rn[0]); end
  endtask

  task automatic test_single_voice();
    do_reset();
    write_voice(3, 0, 32'h004000);
    write_voice(3, 1, 5);
    write_voice(3, 3, 32'h1FFFF);
    write_voice(3, 2, 32'h10000);
    run_sweep(-1, -1, 0, 0, 0);
    checks += 5;
    if (log_rn[3] !== 26) begin errors++; $display("FAIL single_r_time got %0d exp 26", log_rn[3]); end
    if (log_r[3] !== 0) begin errors++; $display("FAIL single_r_addr got %0d exp 0", log_r[3]); end
    if (log_ln[3] !== 27) begin errors++; $display("FAIL single_l_time got %0d exp 27", log_ln[3]); end
    if (log_l[3] !== 5) begin errors++; $display("FAIL single_l_addr got %0d exp 5", log_l[3]); end
    if (log_vel[3] !== 32'h10000) begin errors++; $display("FAIL single_vel got %0h exp 10000", log_vel[3]); end
    run_sweep(-1, -1, 0, 0, 0);
    checks += 2;
    if (log_r[3] !== 1) begin errors++; $display("FAIL single_r_addr2 got %0d exp 1", log_r[3]); end
    if (log_l[3] !== 6) begin errors++; $display("FAIL single_l_addr2 got %0d exp 6", log_l[3]); end
  endtask

  task automatic test_address_wrap();
    do_reset();
    write_voice(7, 0, 32'hFFC000);
    write_voice(7, 1, 1023);
    run_sweep(-1, -1, 0, 0, 0);
    checks += 2;
    if (log_r[7] !== 0) begin errors++; $display("FAIL wrap_r1 got %0d exp 0", log_r[7]); end
    if (log_l[7] !== 1023) begin errors++; $display("FAIL wrap_l1 got %0d exp 1023", log_l[7]); end
    run_sweep(-1, -1, 0, 0, 0);
    checks += 2;
    if (log_r[7] !== 1023) begin errors++; $display("FAIL wrap_r2 got %0d exp 1023", log_r[7]); end
    if (log_l[7] !== 1022) begin errors++; $display("FAIL wrap_l2 got %0d exp 1022", log_l[7]); end
  endtask

  task automatic test_write_collision();
    do_reset();
    write_voice(0, 0, 32'h000100);
    write_voice(0, 2, 32'h123);
    run_sweep(-1, 1, 0, 2, 7);
    checks += 1;
    if (log_vel[0] !== 32'h123) begin errors++; $display("FAIL collide_old_vel got %0h exp 123", log_vel[0]); end
    run_sweep(-1, -1, 0, 0, 0);
    checks += 1;
    if (log_vel[0] !== 7) begin errors++; $display("FAIL collide_new_vel got %0h exp 7", log_vel[0]); end
  endtask

  task automatic test_phase_reset();
    int exp_r;
    do_reset();
    write_voice(2, 0, 32'h004000);
    repeat (3) run_sweep(-1, -1, 0, 0, 0);
    checks += 1;
    if (log_r[2] !== 2) begin errors++; $display("FAIL phase_run got %0d exp 2", log_r[2]); end
    write_voice(2, 0, 32'h004000);
    run_sweep(-1, -1, 0, 0, 0);
`ifdef VOICE_PHASE_RESET_EN
    exp_r = 0;
`else
    exp_r = 3;
`endif
    checks += 1;
    if (log_r[2] !== exp_r) begin errors++; $display("FAIL phase_rewrite got %0d exp %0d", log_r[2], exp_r); end
    // Rewrite landing on the voice's slot cycle 1 (cycle 18)
    run_sweep(-1, 18, 2, 0, 32'h008000);
    run_sweep(-1, -1, 0, 0, 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 8; it++) begin
      for (int w = 0; w < 12; w++) begin
        int f;
        int unsigned d;
        f = $urandom_range(0, 3);
        d = $urandom;
        if (f == 0 && $urandom_range(0, 3) == 0) d = 0;
        write_voice($urandom_range(0, 19), f, d);
      end
      run_sweep(-1, $urandom_range(1, SWEEP_LEN), $urandom_range(0, 17),
                $urandom_range(0, 3), $urandom);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    write_voice(3, 0, 32'h004000);
    write_voice(3, 1, 5);
    run_sweep(50, -1, 0, 0, 0);
    checks += 2;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %0b exp 1", overrun); end
    if (done_n !== 129) begin errors++; $display("FAIL overrun_done_time got %0d exp 129", done_n); end
    run_sweep(-1, -1, 0, 0, 0);
    checks += 2;
    if (log_rn[3] !== 26) begin errors++; $display("FAIL overrun_next_r_time got %0d exp 26", log_rn[3]); end
    if (log_r[3] !== 1) begin errors++; $display("FAIL overrun_next_r got %0d exp 1", log_r[3]); end
  endtask

  task automatic test_reset_mid_sweep();
    do_reset();
    write_voice(1, 0, 32'h004000);
    write_voice(1, 3, 32'h2AAAA);
    @(negedge clk);
    tick48k = 1'b1;
    @(negedge clk);
    tick48k = 1'b0;
    repeat (12) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (busy !== 1'b0 || sweep_done !== 1'b0 || overrun !== 1'b0) begin errors++; $display("FAIL midrst_status got %0b%0b%0b exp 000", busy, sweep_done, overrun); end
    if (wavetable_r !== 10'd0 || wavetable_l !== 10'd0 || wavetable_r_valid !== 1'b0 || wavetable_l_valid !== 1'b0) begin errors++; $display("FAIL midrst_addr got r=%0d l=%0d exp 0", wavetable_r, wavetable_l); end
    if (volume_adsr !== 18'd0 || velocity !== 18'd0) begin errors++; $display("FAIL midrst_env got %0h/%0h exp 0", volume_adsr, velocity); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_sweep(-1, -1, 0, 0, 0);
    checks += 1;
    if (log_rn[1] !== -1) begin errors++; $display("FAIL midrst_no_strobe got %0d exp -1", log_rn[1]); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_voice();
    test_address_wrap();
    test_write_collision();
    test_phase_reset();
    test_random();
    test_overrun();
    test_reset_mid_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
